conv_output_collector: RTL and testbench
========================================

Name: conv_output_collector

Overview:
- Downstream stage of the convolve pipeline. Consumes the per-cycle pixel stream from the multiplier output.
- Tracks row/column position of each result and discards wrapped-window (border) results.
- Buffers kept pixels in a small FIFO and presents them on a valid/ready interface with an end-of-frame marker, decoupling the free-running convolver from a back-pressuring consumer (IO/Wishbone readout).

Parameters:
- BITS, 9, pixel width; matches convolve BITS.
- KERNEL_SIZE, 3, kernel edge length; first KERNEL_SIZE-1 columns of each row are discarded.
- IMG_LENGTH, 16, image row width in pixels.
- IMG_HEIGHT, 16, image rows.
- FIFO_DEPTH, 8, output buffer entries; power of two, >= 2.

Ports:
- clk  input  1  single clock.
- reset_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous; flushes FIFO, counters, overflow flag.
- pix_in  input  BITS  convolver result pixel.
- pix_valid  input  1  pix_in valid this cycle; no back-pressure upstream.
- out_data  output  BITS  FIFO head pixel.
- out_last  output  1  head pixel is the last kept pixel of a frame.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts head when out_valid & out_ready.
- frame_done  output  1  one-cycle pulse after the last input pixel of a frame is processed.
- overflow  output  1  sticky; set when a kept pixel is lost to a full FIFO.
- fill_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
Clock and reset:
- One clock. Reset is asynchronous and active-low (reset_n), applied on negedge reset_n.
- All outputs 0 in reset: out_valid=0, out_last=0, out_data=0, frame_done=0, overflow=0, fill_level=0.
- Counters col=0, row=0; FSM in IDLE.

Position counters (advance only on pix_valid):
- col runs 0..IMG_LENGTH-1 and wraps to 0.
- row runs 0..OUT_ROWS-1, with OUT_ROWS = IMG_HEIGHT-KERNEL_SIZE+1; row increments when col wraps.
- keep = pix_valid & (col >= KERNEL_SIZE-1).
- eof = pix_valid & (col == IMG_LENGTH-1) & (row == OUT_ROWS-1). On eof, row and col both return to 0.
- Kept pixels per frame: (IMG_LENGTH-KERNEL_SIZE+1)*OUT_ROWS, which is 196 at defaults.

FSM:
- IDLE -> ACTIVE on the first pix_valid.
- ACTIVE -> DONE on eof.
- DONE: frame_done=1 for exactly one cycle, then -> IDLE.
- A pix_valid arriving in DONE is processed normally as pixel (row 0, col 0) of the next frame, and the FSM goes to ACTIVE.

FIFO:
- Entries are {last, pixel}, BITS+1 bits wide.
- Push = keep. Entry last = eof. Push and pop in the same cycle are both allowed.
- Write when not full, or when full and a pop happens in the same cycle.
- Write into a full FIFO with no pop: pixel dropped, overflow set to 1 (sticky until clear or reset). Counters still advance.
- Pop = out_valid & out_ready. Pop with out_valid=0 has no effect.
- out_data and out_last show the head entry combinationally from FIFO storage; 0 when empty.
- Latency: a kept pixel at edge N gives out_valid=1 after edge N when the FIFO was empty.
- Read/write pointers wrap modulo FIFO_DEPTH. Full/empty are decided by fill_level.

clear:
- Same effect as reset but synchronous. Takes priority over push/pop in the same cycle; the incoming pixel is discarded.

Arithmetic:
- pix_in is passed through unmodified; no arithmetic on pixels.
- Counter widths are $clog2(IMG_LENGTH) and $clog2(OUT_ROWS), minimum 1.

Reset mid-frame: all state is lost. The next pix_valid is treated as row 0, col 0.

Decomposition:
- Shared package conv_pkg holds the default BITS/KERNEL_SIZE/IMG_LENGTH/IMG_HEIGHT constants, the OUT_ROWS/OUT_COLS derived-constant functions, and the FSM state enum (IDLE, ACTIVE, DONE).
- One sub-module, sync_fifo: parameters WIDTH and DEPTH; ports clk, reset_n, clear, push, pop, wdata, rdata, full, empty, level.

Test Plan:
- Params IMG_LENGTH=4, IMG_HEIGHT=4, KERNEL_SIZE=3, out_ready=1; stream values 1..8 with pix_valid=1 continuously -> outputs 3,4,7,8 in order; out_last=1 only with 8; frame_done pulses once, on the cycle after pixel 8 is processed.
- Same params, out_ready=0 for the whole frame, FIFO_DEPTH=8 -> fill_level reaches 4 and overflow stays 0; then out_ready=1 -> 4 pops, fill_level back to 0.
- FIFO_DEPTH=2, out_ready=0, stream 1..8 -> 3 and 4 buffered; pixels 7 and 8 dropped; overflow=1 and stays 1 through a later frame, until clear=1 for one cycle returns it to 0.
- Gaps: pix_valid pattern 1,0,1,1,0,... -> kept-pixel selection identical to the continuous case; no bubble pixels pushed.
- reset_n pulsed low mid-frame after pixel 5 -> all outputs 0 immediately (async); the restarted stream 1..8 reproduces the first scenario exactly.
- Full FIFO with simultaneous kept pixel and out_ready=1 -> pop and push in the same cycle; fill_level unchanged; no overflow.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants, derived-size helpers and FSM state type for the convolve pipeline.
package conv_pkg;

  localparam int unsigned DefaultBits       = 9;
  localparam int unsigned DefaultKernelSize = 3;
  localparam int unsigned DefaultImgLength  = 16;
  localparam int unsigned DefaultImgHeight  = 16;

  // Rows of valid (non-wrapped) results produced by a full frame.
  function automatic int unsigned out_rows(input int unsigned img_height,
                                           input int unsigned kernel_size);
    return img_height - kernel_size + 1;
  endfunction

  // Columns of valid (non-wrapped) results in each row.
  function automatic int unsigned out_cols(input int unsigned img_length,
                                           input int unsigned kernel_size);
    return img_length - kernel_size + 1;
  endfunction

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StDone   = 2'd2
  } conv_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter; head is read combinationally from storage.
module sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    level_q, level_d;
  logic             do_pop;
  logic             do_write;

  assign empty = (level_q == '0);
  assign full  = (level_q == (PtrW + 1)'(DEPTH));
  assign level = level_q;

  // A write into a full FIFO is only accepted when a pop frees the slot in the same cycle.
  assign do_pop   = pop & ~empty & ~clear;
  assign do_write = push & (~full | do_pop) & ~clear;

  // Head entry, forced to zero while empty so stale storage never leaks out.
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy next state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_write) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)   rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({do_write, do_pop})
        2'b10:   level_d = level_q + (PtrW + 1)'(1);
        2'b01:   level_d = level_q - (PtrW + 1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care while empty, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/conv_output_collector.sv
// Collects the convolver result stream, drops wrapped-window border results and
// buffers kept pixels for a back-pressuring valid/ready consumer.
module conv_output_collector
  import conv_pkg::*;
#(
  parameter int unsigned BITS        = DefaultBits,
  parameter int unsigned KERNEL_SIZE = DefaultKernelSize,
  parameter int unsigned IMG_LENGTH  = DefaultImgLength,
  parameter int unsigned IMG_HEIGHT  = DefaultImgHeight,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clear,
  input  logic [BITS-1:0]               pix_in,
  input  logic                          pix_valid,
  output logic [BITS-1:0]               out_data,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          frame_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

  localparam int unsigned OutRows = out_rows(IMG_HEIGHT, KERNEL_SIZE);
  localparam int unsigned ColW    = clog2_min1(IMG_LENGTH);
  localparam int unsigned RowW    = clog2_min1(OutRows);

  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic            col_last;
  logic            row_last;
  logic            keep;
  logic            eof;

  conv_state_e     state_q, state_d;

  logic            overflow_q, overflow_d;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_pop;
  logic [BITS:0]   fifo_rdata;

  assign col_last = (col_q == ColW'(IMG_LENGTH - 1));
  assign row_last = (row_q == RowW'(OutRows - 1));

  // The first KERNEL_SIZE-1 columns hold windows that wrapped across a row edge.
  assign keep = pix_valid & (col_q >= ColW'(KERNEL_SIZE - 1));
  assign eof  = pix_valid & col_last & row_last;

  // Position counters advance once per valid input pixel.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pix_valid) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  // Position counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (clear) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else if (clear) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame FSM next state; a pixel arriving in StDone starts the next frame directly.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (eof)            state_d = StDone;
        else if (pix_valid) state_d = StActive;
      end
      StActive: begin
        if (eof) state_d = StDone;
      end
      StDone: begin
        if (eof)            state_d = StDone;
        else if (pix_valid) state_d = StActive;
        else                state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Frame FSM outputs.
  always_comb begin
    frame_done = (state_q == StDone);
  end

  assign fifo_pop = out_valid & out_ready;

  // Sticky overflow: a kept pixel arrived with no free slot and no pop to make one.
  always_comb begin
    overflow_d = overflow_q | (keep & fifo_full & ~fifo_pop);
  end

  // Overflow flag register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else if (clear) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;

  sync_fifo #(
    .WIDTH (BITS + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (keep),
    .pop     (fifo_pop),
    .wdata   ({eof, pix_in}),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fill_level)
  );

  assign out_valid = ~fifo_empty;
  assign out_last  = fifo_rdata[BITS];
  assign out_data  = fifo_rdata[BITS-1:0];

endmodule

// File: tb/tb_conv_output_collector.sv
// Bench for conv_output_collector: two instances (deep and shallow FIFO) on a shared
// input stream, compared every cycle against a queue-level reference model.
module tb_conv_output_collector;

  localparam int unsigned L   = 4;
  localparam int unsigned H   = 4;
  localparam int unsigned K   = 3;
  localparam int unsigned OR  = H - K + 1;
  localparam int unsigned FR  = L * OR;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clear;
  logic       pix_valid;
  logic [8:0] pix_in;
  logic       rdy8, rdy2;

  logic [8:0] d8, d2;
  logic       l8, l2, v8, v2, fd8, fd2, ov8, ov2;
  logic [3:0] f8;
  logic [1:0] f2;

  int tests = 0;
  int fails = 0;

  // Reference model state: per-instance queue contents as {last, pixel}.
  int unsigned mdep [2] = '{8, 2};
  logic [9:0]  mq   [2][8];
  int unsigned mcnt [2];
  bit          movf [2];
  bit          mfd;
  int unsigned mp;

  int          pop8 [$];
  int          fd_pulses;

  always #5 clk = ~clk;

  conv_output_collector #(
    .BITS (9), .KERNEL_SIZE (K), .IMG_LENGTH (L), .IMG_HEIGHT (H), .FIFO_DEPTH (8)
  ) dut8 (
    .clk (clk), .reset_n (reset_n), .clear (clear), .pix_in (pix_in),
    .pix_valid (pix_valid), .out_data (d8), .out_last (l8), .out_valid (v8),
    .out_ready (rdy8), .frame_done (fd8), .overflow (ov8), .fill_level (f8)
  );

  conv_output_collector #(
    .BITS (9), .KERNEL_SIZE (K), .IMG_LENGTH (L), .IMG_HEIGHT (H), .FIFO_DEPTH (2)
  ) dut2 (
    .clk (clk), .reset_n (reset_n), .clear (clear), .pix_in (pix_in),
    .pix_valid (pix_valid), .out_data (d2), .out_last (l2), .out_valid (v2),
    .out_ready (rdy2), .frame_done (fd2), .overflow (ov2), .fill_level (f2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mp  = 0;
    mfd = 0;
    for (int i = 0; i < 2; i++) begin
      mcnt[i] = 0;
      movf[i] = 0;
    end
  endtask

  // One clock edge of the collector's behaviour, from the position/keep/queue rules.
  task automatic model_update();
    bit e;
    bit rdy;
    e = 0;
    if (clear) begin
      model_reset();
      return;
    end
    if (pix_valid) e = (mp == FR - 1);
    for (int i = 0; i < 2; i++) begin
      rdy = (i == 0) ? rdy8 : rdy2;
      if (mcnt[i] > 0 && rdy) begin
        for (int j = 0; j < 7; j++) mq[i][j] = mq[i][j+1];
        mcnt[i]--;
      end
      if (pix_valid && (mp % L) >= K - 1) begin
        if (mcnt[i] < mdep[i]) begin
          mq[i][mcnt[i]] = {e, pix_in};
          mcnt[i]++;
        end else begin
          movf[i] = 1;
        end
      end
    end
    if (pix_valid) mp = e ? 0 : mp + 1;
    mfd = e;
  endtask

  task automatic compare_one(input int i, input logic v, input logic [8:0] d, input logic la,
                             input logic [31:0] f, input logic fd, input logic ov);
    logic [9:0] head;
    string      n;
    n    = (i == 0) ? "d8" : "d2";
    head = (mcnt[i] > 0) ? mq[i][0] : 10'd0;
    check({n, ".out_valid"},  32'(v),  32'(mcnt[i] > 0));
    check({n, ".out_data"},   32'(d),  32'(head[8:0]));
    check({n, ".out_last"},   32'(la), 32'(head[9]));
    check({n, ".fill_level"}, f,       mcnt[i]);
    check({n, ".frame_done"}, 32'(fd), 32'(mfd));
    check({n, ".overflow"},   32'(ov), 32'(movf[i]));
  endtask

  task automatic compare_all();
    compare_one(0, v8, d8, l8, 32'(f8), fd8, ov8);
    compare_one(1, v2, d2, l2, 32'(f2), fd2, ov2);
  endtask

  // Called just after a falling edge: drive, take the rising edge, check at the next fall.
  task automatic step(input logic v, input logic [8:0] d);
    pix_valid = v;
    pix_in    = d;
    #1;
    if (v8 && rdy8) pop8.push_back(int'(d8));
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
    if (fd8) fd_pulses++;
    clear = 1'b0;
  endtask

  // Sends pixels first..last; with gaps, valid follows the repeating pattern 1,0,1,1,0.
  task automatic stream(input int first, input int last, input bit gaps);
    int k, ph;
    k  = first;
    ph = 0;
    while (k <= last) begin
      if (gaps && (ph == 1 || ph == 4)) begin
        step(1'b0, 9'h1ff);
      end else begin
        step(1'b1, 9'(k));
        k++;
      end
      ph = (ph + 1) % 5;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 9'd0);
  endtask

  task automatic check_pops(input string tag);
    int exp_pop [4] = '{3, 4, 7, 8};
    check({tag, ".pop_count"}, pop8.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < pop8.size()) check({tag, ".pop_value"}, pop8[i], exp_pop[i]);
      else                 check({tag, ".pop_value"}, 32'hffff_ffff, exp_pop[i]);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    clear     = 1'b0;
    pix_valid = 1'b0;
    pix_in    = '0;
    rdy8      = 1'b0;
    rdy2      = 1'b0;
    fd_pulses = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    reset_n = 1'b1;
    idle(1);

    // Continuous frame with a ready consumer.
    rdy8 = 1'b1;
    rdy2 = 1'b1;
    pop8.delete();
    fd_pulses = 0;
    stream(1, 8, 1'b0);
    idle(3);
    check_pops("cont");
    check("cont.frame_done_pulses", fd_pulses, 1);

    // Stalled consumer: deep FIFO holds the frame, shallow one overflows.
    clear = 1'b1;
    idle(1);
    rdy8 = 1'b0;
    rdy2 = 1'b0;
    stream(1, 8, 1'b0);
    idle(2);
    check("stall.fill8", 32'(f8), 4);
    check("stall.ovf8", 32'(ov8), 0);
    check("stall.fill2", 32'(f2), 2);
    check("stall.ovf2", 32'(ov2), 1);
    rdy8 = 1'b1;
    rdy2 = 1'b1;
    idle(6);
    check("drain.fill8", 32'(f8), 0);
    stream(1, 8, 1'b0);
    idle(3);
    check("sticky.ovf2", 32'(ov2), 1);
    clear = 1'b1;
    idle(1);
    check("clear.ovf2", 32'(ov2), 0);

    // Gapped input must select the same pixels.
    pop8.delete();
    stream(1, 8, 1'b1);
    idle(3);
    check_pops("gaps");

    // Asynchronous reset mid-frame, then a clean restart.
    stream(1, 5, 1'b0);
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    #1;
    reset_n = 1'b1;
    pop8.delete();
    idle(1);
    stream(1, 8, 1'b0);
    idle(3);
    check_pops("restart");

    // Full shallow FIFO with simultaneous push and pop.
    rdy2 = 1'b0;
    stream(1, 6, 1'b0);
    rdy2 = 1'b1;
    step(1'b1, 9'd7);
    check("simul.fill2", 32'(f2), 2);
    check("simul.ovf2", 32'(ov2), 0);
    step(1'b1, 9'd8);
    idle(3);

    // Randomized traffic with occasional clear.
    for (int c = 0; c < 400; c++) begin
      rdy8  = ($urandom_range(0, 3) != 0);
      rdy2  = ($urandom_range(0, 1) != 0);
      clear = ($urandom_range(0, 99) == 0);
      step($urandom_range(0, 9) < 7, 9'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
